// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter
// Packet-granular round-robin arbiter: NUM_PORTS AXI-Stream slaves share one
// registered master stream. A grant is held from the first beat of a packet
// through its tlast handshake, then the arbiter spends one IDLE cycle
// re-arbitrating from the port after the one last served.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | no grant; picks next requester (round robin) for next edge
//   ST_LOCKED | grant_idx owns the output until its tlast beat is accepted
module axis_packet_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int TID_WIDTH     = 4,
  parameter int TUSER_WIDTH   = 1,
  parameter int TID_FROM_PORT = 1,
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int KW = DATA_WIDTH / 8
) (
  input  logic                             aclk,
  input  logic                             areset_n,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*KW-1:0]          s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  input  logic [NUM_PORTS*TID_WIDTH-1:0]   s_axis_tid,
  input  logic [NUM_PORTS*TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KW-1:0]                    m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic [TID_WIDTH-1:0]             m_axis_tid,
  output logic [TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic                             grant_active,
  output logic [GW-1:0]                    grant_idx
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]             state;
  logic [GW-1:0]          last_grant;
  logic [GW-1:0]          pick;
  logic                   pick_found;
  logic                   out_ready;
  logic                   beat_hs;
  logic                   sel_valid;
  logic                   sel_last;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [KW-1:0]          sel_keep;
  logic [TID_WIDTH-1:0]   sel_tid;
  logic [TUSER_WIDTH-1:0] sel_user;

  // The output register can take a new beat when empty or being drained.
  assign out_ready    = m_axis_tready || !m_axis_tvalid;
  assign grant_active = (state == ST_LOCKED);

  assign sel_valid = s_axis_tvalid[grant_idx];
  assign sel_last  = s_axis_tlast[grant_idx];
  assign sel_data  = s_axis_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_keep  = s_axis_tkeep[grant_idx*KW +: KW];
  assign sel_user  = s_axis_tuser[grant_idx*TUSER_WIDTH +: TUSER_WIDTH];
  assign beat_hs   = grant_active && sel_valid && out_ready;

  generate
    if (TID_FROM_PORT != 0) begin : g_tid_port
      assign sel_tid = TID_WIDTH'(grant_idx);
    end else begin : g_tid_pass
      assign sel_tid = s_axis_tid[grant_idx*TID_WIDTH +: TID_WIDTH];
    end
  endgenerate

  // Round-robin scan starting just above the last served port.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!pick_found && s_axis_tvalid[(int'(last_grant) + k) % NUM_PORTS]) begin
        pick       = GW'((int'(last_grant) + k) % NUM_PORTS);
        pick_found = 1'b1;
      end
    end
  end

  // Only the granted port sees ready; it never depends on tvalid.
  always_comb begin
    s_axis_tready = '0;
    if (grant_active) s_axis_tready[grant_idx] = out_ready;
  end

  // Grant state machine and round-robin pointer.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= ST_IDLE;
      last_grant <= GW'(NUM_PORTS - 1);
      grant_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_idx <= pick;
            state     <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (beat_hs && sel_last) begin
            last_grant <= grant_idx;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered output stage; holds everything while downstream stalls.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      m_axis_tuser  <= '0;
    end else if (out_ready) begin
      m_axis_tvalid <= grant_active && sel_valid;
      m_axis_tdata  <= sel_data;
      m_axis_tkeep  <= sel_keep;
      m_axis_tlast  <= sel_last;
      m_axis_tid    <= sel_tid;
      m_axis_tuser  <= sel_user;
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter. A second instance with
// TID_FROM_PORT=0 shares the same slave inputs to cover tid pass-through.
`timescale 1ns/1ps
module tb_axis_packet_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int TW = 4;
  localparam int UW = 1;

  logic              aclk = 1'b0;
  logic              areset_n = 1'b0;
  logic [NP-1:0]     s_tvalid = '0;
  logic [NP*DW-1:0]  s_tdata = '0;
  logic [NP*KW-1:0]  s_tkeep = '0;
  logic [NP-1:0]     s_tlast = '0;
  logic [NP*TW-1:0]  s_tid = '0;
  logic [NP*UW-1:0]  s_tuser = '0;
  logic              m_tready = 1'b1;

  logic [NP-1:0]     s_tready, s_tready_b;
  logic              m_tvalid, m_tvalid_b;
  logic [DW-1:0]     m_tdata, m_tdata_b;
  logic [KW-1:0]     m_tkeep, m_tkeep_b;
  logic              m_tlast, m_tlast_b;
  logic [TW-1:0]     m_tid, m_tid_b;
  logic [UW-1:0]     m_tuser, m_tuser_b;
  logic              g_act, g_act_b;
  logic [1:0]        g_idx, g_idx_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 aclk = ~aclk;

  axis_packet_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TID_WIDTH(TW),
                        .TUSER_WIDTH(UW), .TID_FROM_PORT(1)) u_dut (
    .aclk(aclk), .areset_n(areset_n),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tuser(s_tuser), .m_axis_tready(m_tready), .m_axis_tvalid(m_tvalid),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tid(m_tid), .m_axis_tuser(m_tuser),
    .grant_active(g_act), .grant_idx(g_idx));

  axis_packet_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TID_WIDTH(TW),
                        .TUSER_WIDTH(UW), .TID_FROM_PORT(0)) u_dut_pass (
    .aclk(aclk), .areset_n(areset_n),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_b), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tuser(s_tuser), .m_axis_tready(m_tready), .m_axis_tvalid(m_tvalid_b),
    .m_axis_tdata(m_tdata_b), .m_axis_tkeep(m_tkeep_b), .m_axis_tlast(m_tlast_b),
    .m_axis_tid(m_tid_b), .m_axis_tuser(m_tuser_b),
    .grant_active(g_act_b), .grant_idx(g_idx_b));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic [63:0] d, input logic l);
    s_tvalid[p]          = v;
    s_tdata[p*DW +: DW]  = d;
    s_tlast[p]           = l;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tid = '0; s_tuser = '0;
    m_tready = 1'b1;
    tick(); tick();
    areset_n = 1'b1;
  endtask

  logic [NP-1:0] hs;
  logic [63:0]   md;
  logic          mv, mr;
  int            nn [NP];
  int            bb [NP];
  int            j, first_c, last_c, k, idx;
  logic [31:0]   pat;

  initial begin
    // ---------------- reset state
    do_reset();
    check("rst grant_active", g_act, 0);
    check("rst grant_idx", g_idx, 0);
    check("rst s_tready", s_tready, 0);
    check("rst m_tvalid", m_tvalid, 0);
    check("rst m_tdata", m_tdata, 0);
    check("rst m_tlast", m_tlast, 0);
    check("rst m_tid", m_tid, 0);

    // ---------------- port 2, three-beat packet
    drive(2, 1, 64'hA0, 0);                // cycle 0
    check("t1 c0 grant_active", g_act, 0);
    tick();                                // cycle 1
    check("t1 c1 grant_active", g_act, 1);
    check("t1 c1 grant_idx", g_idx, 2);
    check("t1 c1 s_tready", s_tready, 4'b0100);
    check("t1 c1 m_tvalid", m_tvalid, 0);
    tick();                                // cycle 2
    check("t1 c2 m_tvalid", m_tvalid, 1);
    check("t1 c2 m_tdata", m_tdata, 64'hA0);
    check("t1 c2 m_tid", m_tid, 2);
    check("t1 c2 m_tlast", m_tlast, 0);
    drive(2, 1, 64'hA1, 0);
    tick();                                // cycle 3
    check("t1 c3 m_tdata", m_tdata, 64'hA1);
    drive(2, 1, 64'hA2, 1);
    tick();                                // cycle 4
    drive(2, 0, 64'h0, 0);
    check("t1 c4 m_tdata", m_tdata, 64'hA2);
    check("t1 c4 m_tlast", m_tlast, 1);
    check("t1 c4 grant_active", g_act, 0);
    check("t1 c4 s_tready", s_tready, 0);
    tick();
    check("t1 c5 m_tvalid", m_tvalid, 0);

    // ---------------- all ports stream 2-beat packets
    do_reset();
    for (int p = 0; p < NP; p++) begin
      nn[p] = 0; bb[p] = 0;
      drive(p, 1, 64'(p*256), 0);
    end
    j = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 80 && j < 16; c++) begin
      #1;
      hs = s_tready & s_tvalid;
      tick();
      for (int p = 0; p < NP; p++) begin
        if (hs[p]) begin
          if (bb[p] == 1) begin bb[p] = 0; nn[p]++; end
          else bb[p] = 1;
          drive(p, 1, 64'(p*256 + nn[p]*16 + bb[p]), bb[p] == 1);
        end
      end
      if (m_tvalid) begin
        check("t2 data", m_tdata, 64'(((j/2)%NP)*256 + (j/8)*16 + (j%2)));
        check("t2 tid", m_tid, 64'((j/2)%NP));
        check("t2 tlast", m_tlast, 64'(j%2));
        if (j == 0) first_c = c;
        if (j == 15) last_c = c;
        j++;
      end
    end
    check("t2 beat count", 64'(j), 16);
    check("t2 bubble spacing", 64'(last_c - first_c), 22);

    // ---------------- port 1 stalls mid-packet while port 3 requests
    do_reset();
    drive(1, 1, 64'hB0, 0);
    tick();
    check("t3 grant_idx", g_idx, 1);
    tick();
    check("t3 m_tdata B0", m_tdata, 64'hB0);
    drive(1, 0, 64'h0, 0);
    drive(3, 1, 64'hC0, 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t3 stall grant_idx", g_idx, 1);
      check("t3 stall grant_active", g_act, 1);
      check("t3 stall s_tready", s_tready, 4'b0010);
    end
    check("t3 stall m_tvalid", m_tvalid, 0);
    drive(1, 1, 64'hB1, 1);
    tick();
    drive(1, 0, 64'h0, 0);
    check("t3 B1 out", m_tdata, 64'hB1);
    check("t3 bubble grant_active", g_act, 0);
    tick();
    check("t3 port3 grant_idx", g_idx, 3);
    check("t3 port3 s_tready", s_tready, 4'b1000);
    tick();
    drive(3, 0, 64'h0, 0);
    check("t3 C0 out", m_tdata, 64'hC0);
    check("t3 C0 tid", m_tid, 3);

    // ---------------- 16-beat packet with m_tready toggling
    do_reset();
    pat = 32'hB5E3_9A6D;
    idx = 0; k = 0;
    drive(0, 1, 64'hD00, 0);
    for (int c = 0; c < 100 && k < 16; c++) begin
      m_tready = pat[c % 32];
      #1;
      hs[0] = s_tready[0] & s_tvalid[0];
      mv = m_tvalid; mr = m_tready; md = m_tdata;
      if (mv && mr) begin
        check("t4 data", md, 64'(64'hD00 + k));
        k++;
      end
      tick();
      if (mv && !mr) begin
        check("t4 hold valid", m_tvalid, 1);
        check("t4 hold data", m_tdata, md);
      end
      if (hs[0]) begin
        idx++;
        if (idx < 16) drive(0, 1, 64'(64'hD00 + idx), idx == 15);
        else drive(0, 0, 64'h0, 0);
      end
    end
    check("t4 beat count", 64'(k), 16);
    m_tready = 1'b1;

    // ---------------- asynchronous reset during 3rd beat of 6
    do_reset();
    drive(2, 1, 64'hE0, 0);
    tick();
    tick();
    drive(2, 1, 64'hE1, 0);
    tick();
    drive(2, 1, 64'hE2, 0);
    check("t5 pre-reset m_tdata", m_tdata, 64'hE1);
    #2 areset_n = 1'b0;
    #1;
    check("t5 async m_tvalid", m_tvalid, 0);
    check("t5 async m_tdata", m_tdata, 0);
    check("t5 async grant_active", g_act, 0);
    check("t5 async grant_idx", g_idx, 0);
    check("t5 async s_tready", s_tready, 0);
    drive(0, 1, 64'hF0, 1);
    #2 areset_n = 1'b1;
    tick();
    check("t5 post grant_idx", g_idx, 0);
    check("t5 post grant_active", g_act, 1);
    check("t5 post m_tvalid", m_tvalid, 0);

    // ---------------- tid/tuser/tkeep pass-through
    do_reset();
    drive(1, 1, 64'hF1, 1);
    s_tid[1*TW +: TW]  = 4'h9;
    s_tuser[1]         = 1'b1;
    s_tkeep[1*KW +: KW] = 8'h0F;
    tick();
    tick();
    drive(1, 0, 64'h0, 0);
    check("t6 pass m_tvalid", m_tvalid_b, 1);
    check("t6 pass m_tid", m_tid_b, 4'h9);
    check("t6 pass m_tuser", m_tuser_b, 1);
    check("t6 pass m_tkeep", m_tkeep_b, 8'h0F);
    check("t6 port m_tid", m_tid, 1);
    check("t6 port m_tkeep", m_tkeep, 8'h0F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
